// File: rtl/ex_issue_ctrl_if.sv
// Decode, EX, writeback and status signals of the issue controller, bundled as one port.
// slave: the controller; master: the surrounding pipeline (decode/EX/WB) or a bench.
interface ex_issue_ctrl_if #(
    parameter int NREG  = 32,
    parameter int RIDX  = 5,
    parameter int DEPTH = 2
);
    logic                     i_id_valid;
    logic                     o_id_ready;
    logic [RIDX-1:0]          i_id_rd;
    logic [RIDX-1:0]          i_id_rs1;
    logic [RIDX-1:0]          i_id_rs2;
    logic                     i_id_writes_rd;
    logic                     i_id_uses_rs2;
    logic                     o_ex_start;
    logic [$clog2(DEPTH)-1:0] o_ex_slot;
    logic                     i_ex_done;
    logic                     i_ex_branch;
    logic                     i_wb_valid;
    logic [RIDX-1:0]          i_wb_rd;
    logic                     o_flush;
    logic [NREG-1:0]          o_busy;
    logic [31:0]              o_stall_cnt;

    modport slave (
        input  i_id_valid, i_id_rd, i_id_rs1, i_id_rs2, i_id_writes_rd, i_id_uses_rs2,
        input  i_ex_done, i_ex_branch, i_wb_valid, i_wb_rd,
        output o_id_ready, o_ex_start, o_ex_slot, o_flush, o_busy, o_stall_cnt
    );

    modport master (
        output i_id_valid, i_id_rd, i_id_rs1, i_id_rs2, i_id_writes_rd, i_id_uses_rs2,
        output i_ex_done, i_ex_branch, i_wb_valid, i_wb_rd,
        input  o_id_ready, o_ex_start, o_ex_slot, o_flush, o_busy, o_stall_cnt
    );
endinterface

// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl: in-order issue controller, DEPTH-entry buffer plus RAW busy scoreboard.
// Optional macro EX_ISSUE_STALL_CNT_EN builds the saturating hazard stall counter.
//
// state | meaning
// IDLE  | wait for a non-empty buffer whose head is not blocked
// ISSUE | pulse ex_start, pop the head, mark its rd busy
// WAIT  | instruction in EX, wait for ex_done
// FLUSH | taken branch: pulse flush, empty the buffer
module ex_issue_ctrl #(
    parameter int NREG  = 32,
    parameter int RIDX  = 5,
    parameter int DEPTH = 2
) (
    input  logic           i_clk,
    input  logic           i_reset,
    ex_issue_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;

    typedef struct packed {
        logic [RIDX-1:0] rd;
        logic [RIDX-1:0] rs1;
        logic [RIDX-1:0] rs2;
        logic            writes_rd;
        logic            uses_rs2;
    } entry_t;

    state_t          state_q;
    entry_t          buf_q [DEPTH];
    entry_t          head_e;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d, ex_slot_q;
    logic [CW-1:0]   count_q, count_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            ex_start_q, flush_q;
    logic            id_ready, push, pop, has_head, blocked;

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_e   = buf_q[head_q];
    assign has_head = (count_q != '0);
    assign blocked  = busy_q[head_e.rs1] || (head_e.uses_rs2 && busy_q[head_e.rs2]);
    assign id_ready = !i_reset && (count_q < CW'(DEPTH)) && (state_q != S_FLUSH);
    assign push     = bus.i_id_valid && id_ready;
    assign pop      = (state_q == S_ISSUE);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        if (push) tail_d = nxt_ptr(tail_q);
        if (pop)  head_d = nxt_ptr(head_q);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        if (state_q == S_FLUSH) begin
            count_d = '0;
            head_d  = tail_q;
        end
        // set after clear so an issue marking rd wins over a same-cycle writeback of rd
        if (bus.i_wb_valid)             busy_d[bus.i_wb_rd] = 1'b0;
        if (pop && head_e.writes_rd)    busy_d[head_e.rd]   = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            ex_start_q <= 1'b0;
            ex_slot_q  <= '0;
            flush_q    <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            ex_start_q <= 1'b0;
            flush_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (has_head && !blocked) begin
                        state_q    <= S_ISSUE;
                        ex_start_q <= 1'b1;
                        ex_slot_q  <= head_q;
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (bus.i_ex_done) begin
                        if (bus.i_ex_branch) begin
                            state_q <= S_FLUSH;
                            flush_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_FLUSH: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_q[tail_q] <= {bus.i_id_rd, bus.i_id_rs1, bus.i_id_rs2,
                              bus.i_id_writes_rd, bus.i_id_uses_rs2};
        end
    end

`ifdef EX_ISSUE_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_q <= '0;
        end else if ((state_q == S_IDLE) && has_head && blocked && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.o_stall_cnt = stall_q;
`else
    assign bus.o_stall_cnt = '0;
`endif

    assign bus.o_id_ready = id_ready;
    assign bus.o_ex_start = ex_start_q;
    assign bus.o_ex_slot  = ex_slot_q;
    assign bus.o_flush    = flush_q;
    assign bus.o_busy     = busy_q;
endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Bench for ex_issue_ctrl: directed sequences, a queue-based reference model checked every cycle,
// and literal expectations at key points. Honors EX_ISSUE_STALL_CNT_EN when defined.
`timescale 1ns/1ps
module tb_ex_issue_ctrl;
    localparam int NREG  = 32;
    localparam int RIDX  = 5;
    localparam int DEPTH = 2;
`ifdef EX_ISSUE_STALL_CNT_EN
    localparam logic [31:0] RAW_STALLS = 32'd4;
`else
    localparam logic [31:0] RAW_STALLS = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_issue_ctrl_if #(.NREG(NREG), .RIDX(RIDX), .DEPTH(DEPTH)) bus ();
    ex_issue_ctrl #(.NREG(NREG), .RIDX(RIDX), .DEPTH(DEPTH)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    typedef struct {
        int rd;
        int rs1;
        int rs2;
        bit w;
        bit u;
        int slot;
    } ins_t;

    int errs   = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // reference model: the buffer is a queue, the scoreboard a bit vector,
    // and the controller phase is three flags
    ins_t            mq[$];
    logic [NREG-1:0] m_busy  = '0;
    bit              m_in_ex = 1'b0;
    bit              m_start = 1'b0;
    bit              m_flush = 1'b0;
    int              m_slot  = 0;
    int              m_tail  = 0;
    logic [31:0]     m_stall = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit blocked(input ins_t e, input logic [NREG-1:0] b);
        return b[e.rs1] || (e.u && b[e.rs2]);
    endfunction

    function automatic bit exp_ready();
        return !rst && (mq.size() < DEPTH) && !m_flush;
    endfunction

    always @(posedge clk) begin : model
        bit acc, idle, nstart, nflush;
        logic [NREG-1:0] bn;
        ins_t e;
        if (rst) begin
            mq.delete();
            m_busy  = '0;
            m_in_ex = 1'b0;
            m_start = 1'b0;
            m_flush = 1'b0;
            m_slot  = 0;
            m_tail  = 0;
            m_stall = '0;
        end else begin
            acc    = bus.i_id_valid && exp_ready();
            idle   = !m_in_ex && !m_start && !m_flush;
            nstart = 1'b0;
            nflush = 1'b0;
            bn     = m_busy;
            if (bus.i_wb_valid) bn[bus.i_wb_rd] = 1'b0;
            if (idle && mq.size() > 0) begin
                if (blocked(mq[0], m_busy)) begin
`ifdef EX_ISSUE_STALL_CNT_EN
                    if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
                end else begin
                    nstart = 1'b1;
                    m_slot = mq[0].slot;
                end
            end
            if (m_start) begin
                e = mq.pop_front();
                if (e.w) bn[e.rd] = 1'b1;
                m_in_ex = 1'b1;
            end else if (m_in_ex && bus.i_ex_done) begin
                m_in_ex = 1'b0;
                nflush  = bus.i_ex_branch;
            end
            if (m_flush) mq.delete();
            if (acc) begin
                e.rd   = int'(bus.i_id_rd);
                e.rs1  = int'(bus.i_id_rs1);
                e.rs2  = int'(bus.i_id_rs2);
                e.w    = bus.i_id_writes_rd;
                e.u    = bus.i_id_uses_rs2;
                e.slot = m_tail;
                mq.push_back(e);
                m_tail = (m_tail + 1) % DEPTH;
            end
            bn[0]   = 1'b0;
            m_busy  = bn;
            m_start = nstart;
            m_flush = nflush;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("id_ready", 64'(bus.o_id_ready), 64'(exp_ready()));
            chk("ex_start", 64'(bus.o_ex_start), 64'(m_start));
            if (m_start) chk("ex_slot", 64'(bus.o_ex_slot), 64'(m_slot));
            chk("flush", 64'(bus.o_flush), 64'(m_flush));
            chk("busy", 64'(bus.o_busy), 64'(m_busy));
            chk("stall_cnt", 64'(bus.o_stall_cnt), 64'(m_stall));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.i_id_valid  = 1'b0;
        bus.i_ex_done   = 1'b0;
        bus.i_ex_branch = 1'b0;
        bus.i_wb_valid  = 1'b0;
    endtask

    task automatic set_ins(input int rd, input int rs1, input int rs2, input bit w, input bit u);
        bus.i_id_valid     = 1'b1;
        bus.i_id_rd        = RIDX'(rd);
        bus.i_id_rs1       = RIDX'(rs1);
        bus.i_id_rs2       = RIDX'(rs2);
        bus.i_id_writes_rd = w;
        bus.i_id_uses_rs2  = u;
    endtask

    task automatic wb(input int rd);
        bus.i_wb_valid = 1'b1;
        bus.i_wb_rd    = RIDX'(rd);
    endtask

    task automatic push_wait(input string name, input int rd, input int rs1, input int rs2,
                             input bit w, input bit u);
        int n;
        n = 0;
        set_ins(rd, rs1, rs2, w, u);
        while (!bus.o_id_ready && n < 20) begin
            tick();
            set_ins(rd, rs1, rs2, w, u);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errs++;
            $display("FAIL %s: id_ready never rose within 20 cycles", name);
        end
        tick();
    endtask

    initial begin
        bus.i_id_valid     = 1'b0;
        bus.i_id_rd        = '0;
        bus.i_id_rs1       = '0;
        bus.i_id_rs2       = '0;
        bus.i_id_writes_rd = 1'b0;
        bus.i_id_uses_rs2  = 1'b0;
        bus.i_ex_done      = 1'b0;
        bus.i_ex_branch    = 1'b0;
        bus.i_wb_valid     = 1'b0;
        bus.i_wb_rd        = '0;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        chk("rst_ready", 64'(bus.o_id_ready), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_start", 64'(bus.o_ex_start), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus.o_id_ready), 64'd1);

        // single ADDI x5, x1
        set_ins(5, 1, 0, 1'b1, 1'b0);
        tick();
        tick();
        chk("addi_start", 64'(bus.o_ex_start), 64'd1);
        chk("addi_slot", 64'(bus.o_ex_slot), 64'd0);
        tick();
        chk("addi_busy", 64'(bus.o_busy), 64'h20);
        chk("addi_start_pulse", 64'(bus.o_ex_start), 64'd0);
        bus.i_ex_done = 1'b1;
        tick();
        wb(5);
        tick();
        chk("addi_wb_clear", 64'(bus.o_busy), 64'd0);

        // RAW: ADD x3 then a reader of x3
        set_ins(3, 1, 2, 1'b1, 1'b1);
        tick();
        set_ins(4, 3, 0, 1'b1, 1'b0);
        tick();
        chk("raw_a_slot", 64'(bus.o_ex_slot), 64'd1);
        tick();
        chk("raw_busy3", 64'(bus.o_busy), 64'h8);
        bus.i_ex_done = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("raw_blocked", 64'(bus.o_ex_start), 64'd0);
        wb(3);
        tick();
        chk("raw_idle_after_wb", 64'(bus.o_ex_start), 64'd0);
        tick();
        chk("raw_b_start", 64'(bus.o_ex_start), 64'd1);
        chk("raw_b_slot", 64'(bus.o_ex_slot), 64'd0);
        chk("raw_stall_cnt", 64'(bus.o_stall_cnt), 64'(RAW_STALLS));
        tick();
        bus.i_ex_done = 1'b1;
        tick();
        wb(4);
        tick();
        chk("raw_wb_clear", 64'(bus.o_busy), 64'd0);

        // full buffer while EX is held busy
        set_ins(6, 0, 0, 1'b1, 1'b0);
        tick();
        set_ins(10, 0, 0, 1'b1, 1'b0);
        tick();
        chk("full_ready_low", 64'(bus.o_id_ready), 64'd0);
        chk("full_c1_slot", 64'(bus.o_ex_slot), 64'd1);
        push_wait("full_third_accept", 11, 0, 0, 1'b1, 1'b0);
        chk("full_ready_again", 64'(bus.o_id_ready), 64'd0);
        chk("full_busy6", 64'(bus.o_busy), 64'h40);

        // taken branch with two entries queued
        bus.i_ex_done   = 1'b1;
        bus.i_ex_branch = 1'b1;
        tick();
        chk("br_flush", 64'(bus.o_flush), 64'd1);
        chk("br_ready_low", 64'(bus.o_id_ready), 64'd0);
        set_ins(9, 0, 0, 1'b1, 1'b0);
        tick();
        chk("br_flush_pulse", 64'(bus.o_flush), 64'd0);
        chk("br_ready_empty", 64'(bus.o_id_ready), 64'd1);
        tick();
        tick();
        chk("br_no_start", 64'(bus.o_ex_start), 64'd0);
        chk("br_busy_kept", 64'(bus.o_busy), 64'h40);
        wb(6);
        tick();

        // same-cycle writeback of x7 and issue of a writer of x7
        set_ins(7, 0, 0, 1'b1, 1'b0);
        tick();
        tick();
        set_ins(7, 0, 0, 1'b1, 1'b0);
        tick();
        chk("waw_busy7", 64'(bus.o_busy), 64'h80);
        bus.i_ex_done = 1'b1;
        tick();
        tick();
        chk("same_start", 64'(bus.o_ex_start), 64'd1);
        chk("same_slot", 64'(bus.o_ex_slot), 64'd1);
        wb(7);
        tick();
        chk("same_cycle_busy7", 64'(bus.o_busy), 64'h80);
        bus.i_ex_done = 1'b1;
        tick();
        wb(7);
        tick();

        // x0 target never marks busy
        set_ins(0, 0, 0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk("x0_busy", 64'(bus.o_busy), 64'd0);
        bus.i_ex_done = 1'b1;
        wb(0);
        tick();

        // reset while in WAIT with an entry queued
        set_ins(12, 1, 0, 1'b1, 1'b0);
        tick();
        tick();
        set_ins(13, 12, 0, 1'b1, 1'b0);
        tick();
        chk("pre_rst_busy", 64'(bus.o_busy), 64'h1000);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 64'(bus.o_busy), 64'd0);
        chk("mid_rst_ready", 64'(bus.o_id_ready), 64'd0);
        chk("mid_rst_start", 64'(bus.o_ex_start), 64'd0);
        chk("mid_rst_flush", 64'(bus.o_flush), 64'd0);
        chk("mid_rst_slot", 64'(bus.o_ex_slot), 64'd0);
        chk("mid_rst_stall", 64'(bus.o_stall_cnt), 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_release_ready", 64'(bus.o_id_ready), 64'd1);
        bus.i_ex_done = 1'b1;
        tick();
        tick();
        chk("stray_done_ignored", 64'(bus.o_ex_start), 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ex_issue_ctrl.md
# ex_issue_ctrl

In-order issue controller between the decode stage and the ALU/EX stage. Buffers up to two decoded instructions, blocks issue on read-after-write hazards using a per-register busy scoreboard, and starts the EX stage one instruction at a time. Waits for EX completion, and flushes the buffer when EX resolves a taken branch or jump.

## Interface
- `NREG`, default 32: architectural register count. Scoreboard width.
- `RIDX`, default 5: register index width, equal to clog2(NREG).
- `DEPTH`, default 2: issue buffer entries. Must be 2 or more.
- `i_clk` in 1: clock.
- `i_reset` in 1: reset, synchronous, active-high. Clock is i_clk.
- `i_id_valid` in 1: decode presents an instruction.
- `o_id_ready` out 1: controller accepts the instruction this cycle.
- `i_id_rd`, `i_id_rs1`, `i_id_rs2` in RIDX each: destination and source indices.
- `i_id_writes_rd` in 1: instruction writes rd.
- `i_id_uses_rs2` in 1: rs2 is a real source. It is 0 for immediate ALU ops, LUI/AUIPC, JAL and loads.
- `o_ex_start` out 1: one-cycle pulse that starts EX. Drives the EX pipeline-ready input.
- `o_ex_slot` out 1: buffer slot index of the issued entry. Valid with o_ex_start.
- `i_ex_done` in 1: EX completed the issued instruction. This is a one-cycle pulse.
- `i_ex_branch` in 1: taken branch/jump. Sampled only when i_ex_done=1.
- `i_wb_valid` in 1, `i_wb_rd` in RIDX: writeback retires rd. Clears its busy bit.
- `o_flush` out 1: one-cycle pulse. Upstream must discard fetched/decoded work.
- `o_busy` out NREG: scoreboard. Bit n=1 means a write to xn is pending.
- `o_stall_cnt` out 32: hazard stall counter (see Configuration).

## Operation
- The buffer is a circular FIFO with head/tail pointers and a count, 0..DEPTH.
- Each entry stores {rd, rs1, rs2, writes_rd, uses_rs2}.
- Accept: o_id_ready = (count<DEPTH) && state!=FLUSH. An entry is pushed at the edge where i_id_valid && o_id_ready.
- Hazard: the head is blocked when o_busy[rs1] is set, or when uses_rs2 && o_busy[rs2] is set. Bit 0 of o_busy is always 0.
- State machine:
  - IDLE: if count>0 and the head is not blocked, go to ISSUE.
  - ISSUE: assert o_ex_start and o_ex_slot=head. Pop the head. If writes_rd && rd!=0, set busy[rd]. Go to WAIT.
  - WAIT: hold until i_ex_done. If i_ex_branch=1, go to FLUSH. Otherwise go to IDLE.
  - FLUSH: assert o_flush. Clear the buffer (count=0, head=tail). Busy bits are kept. Go to IDLE.
- Busy bits are cleared only by writeback. If writeback clears rd in the same cycle that ISSUE sets the same rd, the set wins.
- If a push and a pop occur in the same cycle, count is unchanged.
- Head/tail wrap modulo DEPTH.
- An instruction is never issued while one is already in EX.

## Timing
- Reset values: o_id_ready=0 during reset and 1 in the first cycle after reset. o_ex_start=0, o_ex_slot=0, o_flush=0, o_busy=0, o_stall_cnt=0. State is IDLE and the buffer is empty.
- Reset asserted mid-operation aborts the in-flight EX tracking and clears everything.
- Accept-to-start latency with no hazard:
  - Push at edge N, then IDLE→ISSUE at N+1, then o_ex_start high during cycle N+1..N+2. That is 2 cycles.
- Issue rate: at most one issue per 3 cycles (ISSUE, WAIT≥1, IDLE).
- Taken branch: o_flush is high in the cycle after i_ex_done. o_id_ready=0 in that cycle. Pushes attempted during FLUSH are not accepted.
- i_ex_done received outside WAIT is ignored.
- Writeback of rd=0 has no effect.

## Configuration
- `EX_ISSUE_STALL_CNT_EN` defined:
  - o_stall_cnt increments in every cycle where state=IDLE, count>0 and the head is blocked.
  - It saturates at 0xFFFFFFFF and clears only on reset.
- Not defined: o_stall_cnt is tied to 0 and no counter logic is built.

## Test plan
- Single ADDI x5 (rs1=x1, no rs2): push at cycle 1 → o_ex_start at cycle 2, o_busy[5]=1. i_ex_done at cycle 4, then wb x5 at cycle 5 → o_busy=0.
- RAW stall: ADD x3 is issued. A following instruction with rs1=x3 stays blocked until wb x3. Its o_ex_start comes 2 cycles after the wb edge. With the macro, o_stall_cnt equals the blocked cycles.
- Full buffer: push 3 instructions back-to-back while EX is held busy → o_id_ready=0 after 2 accepts. The third is accepted after the next issue pops.
- Taken branch: done with i_ex_branch=1 and 2 entries queued → o_flush pulses 1 cycle, count=0, no o_ex_start for the flushed entries.
- Same-cycle wb x7 and ISSUE of an instruction writing x7 → o_busy[7]=1 afterwards.
- x0 target: instruction with writes_rd=1, rd=0 → o_busy stays 0. Reset in WAIT → all outputs return to their reset values in the next cycle.
